// File: rtl/rvc_pack_encoder.sv
// rvc_pack_encoder: re-encodes a stream of RV32I instructions, compressing a
// fixed subset (C.ADDI, C.LI, C.MV, C.ADD, C.LW, C.SW) into 16-bit RVC form.
// The mixed 16/32-bit result is packed into 32-bit memory words, with the
// lowest-address byte in [31:24].
module rvc_pack_encoder #(
    parameter int COMPRESS_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             busy,
    output logic [CNT_W-1:0] c16_cnt
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    // Halfword used to pad a trailing 16-bit half: C.NOP in memory byte order.
    localparam logic [15:0] NOP_FIELD = 16'h0100;

    state_t      state;
    logic        hold_valid;
    logic [15:0] hold_hw;

    logic [16:0] cmp;       // {eligible, RVC halfword}
    logic        is16;
    logic [15:0] field;     // compressed halfword in memory byte order
    logic [31:0] bytes;     // 32-bit instruction in memory byte order
    logic        can_emit;
    logic        in_fire;
    logic        hold_nxt;

    // Returns {1, halfword} when the instruction has an RVC equivalent,
    // otherwise all zeros.
    function automatic logic [16:0] rvc_compress(input logic [31:0] i);
        logic [6:0]        opc;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic signed [11:0] imm_i;
        logic              imm6_ok;
        logic [16:0]       r;
        r       = '0;
        opc     = i[6:0];
        f3      = i[14:12];
        f7      = i[31:25];
        rd      = i[11:7];
        rs1     = i[19:15];
        rs2     = i[24:20];
        imm_i   = $signed(i[31:20]);
        imm6_ok = (imm_i >= -12'sd32) && (imm_i <= 12'sd31);
        if (opc == 7'b0010011 && f3 == 3'b000) begin
            // addi: in-place add takes priority, otherwise load-immediate from x0
            if (rd == rs1 && rd != 5'd0 && imm_i != 12'sd0 && imm6_ok)
                r = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (rs1 == 5'd0 && rd != 5'd0 && imm6_ok)
                r = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0) begin
            if (rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
                r = {1'b1, 4'b1000, rd, rs2, 2'b10};
            else if (rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
                r = {1'b1, 4'b1001, rd, rs2, 2'b10};
        end else if (opc == 7'b0000011 && f3 == 3'b010) begin
            // offset must be 0..124 and word aligned: imm[11:7]==0, imm[1:0]==0
            if (rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 &&
                i[31:27] == 5'd0 && i[21:20] == 2'd0)
                r = {1'b1, 3'b010, i[25:23], rs1[2:0], i[22], i[26], rd[2:0], 2'b00};
        end else if (opc == 7'b0100011 && f3 == 3'b010) begin
            if (rs1[4:3] == 2'b01 && rs2[4:3] == 2'b01 &&
                i[31:27] == 5'd0 && i[8:7] == 2'd0)
                r = {1'b1, 3'b110, i[25], i[11:10], rs1[2:0], i[9], i[26], rs2[2:0], 2'b00};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign cmp      = (COMPRESS_EN != 0) ? rvc_compress(in_instr) : 17'd0;
    assign is16     = cmp[16];
    assign field    = {cmp[7:0], cmp[15:8]};
    assign bytes    = {in_instr[7:0], in_instr[15:8], in_instr[23:16], in_instr[31:24]};
    assign can_emit = ~out_valid | out_ready;
    assign in_ready = (state == RUN) & can_emit;
    assign in_fire  = in_valid & in_ready;
    // A 16-bit result toggles the pending half; a 32-bit one always leaves it as is.
    assign hold_nxt = is16 ? ~hold_valid : hold_valid;
    assign busy     = hold_valid | (state == FLUSH);

    // Packing state machine with registered output word and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            hold_valid <= 1'b0;
            hold_hw    <= 16'd0;
            out_valid  <= 1'b0;
            out_word   <= 32'd0;
            c16_cnt    <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (in_fire) begin
                        if (is16) begin
                            c16_cnt <= sat_inc(c16_cnt);
                            if (hold_valid) begin
                                out_word   <= {hold_hw, field};
                                out_valid  <= 1'b1;
                                hold_valid <= 1'b0;
                            end else begin
                                hold_hw    <= field;
                                hold_valid <= 1'b1;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            if (hold_valid) begin
                                out_word <= {hold_hw, bytes[31:16]};
                                hold_hw  <= bytes[15:0];
                            end else begin
                                out_word <= bytes;
                            end
                        end
                        if (in_last && hold_nxt)
                            state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (can_emit) begin
                        out_word   <= {hold_hw, NOP_FIELD};
                        out_valid  <= 1'b1;
                        hold_valid <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rvc_pack_encoder.sv
// Testbench for rvc_pack_encoder: scoreboard of expected packed words built
// from hand-encoded RVC halfwords, plus direct checks of control outputs.
module tb_rvc_pack_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main instance (compression on)
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        busy;
    logic [15:0] c16_cnt;

    // compression disabled instance
    logic        nc_in_valid = 1'b0;
    logic        nc_in_ready;
    logic [31:0] nc_in_instr = 32'd0;
    logic        nc_out_valid;
    logic [31:0] nc_out_word;
    logic        nc_busy;
    logic [15:0] nc_c16;

    // narrow counter instance for saturation
    logic        sat_in_valid = 1'b0;
    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [31:0] sat_out_word;
    logic        sat_busy;
    logic [1:0]  sat_c16;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] sb[$];
    logic        m_hold_v = 1'b0;
    logic [15:0] m_hold = 16'd0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    rvc_pack_encoder #(.COMPRESS_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .busy(busy), .c16_cnt(c16_cnt));

    rvc_pack_encoder #(.COMPRESS_EN(0), .CNT_W(16)) u_nc (
        .clk(clk), .rst(rst_n), .in_valid(nc_in_valid), .in_ready(nc_in_ready),
        .in_instr(nc_in_instr), .in_last(1'b0), .out_valid(nc_out_valid),
        .out_ready(1'b1), .out_word(nc_out_word), .busy(nc_busy), .c16_cnt(nc_c16));

    rvc_pack_encoder #(.COMPRESS_EN(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_n), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_instr(32'h00150513), .in_last(1'b0), .out_valid(sat_out_valid),
        .out_ready(1'b1), .out_word(sat_out_word), .busy(sat_busy), .c16_cnt(sat_c16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected packing: is16/hw give the hand-encoded RVC form of the instruction.
    task automatic model_accept(input logic [31:0] instr, input logic last,
                                input logic is16, input logic [15:0] hw);
        logic [15:0] fld;
        logic [31:0] b;
        fld = {hw[7:0], hw[15:8]};
        b   = {instr[7:0], instr[15:8], instr[23:16], instr[31:24]};
        if (is16) begin
            m_cnt++;
            if (m_hold_v) begin
                sb.push_back({m_hold, fld});
                m_hold_v = 1'b0;
            end else begin
                m_hold   = fld;
                m_hold_v = 1'b1;
            end
        end else if (m_hold_v) begin
            sb.push_back({m_hold, b[31:16]});
            m_hold = b[15:0];
        end else begin
            sb.push_back(b);
        end
        if (last && m_hold_v) begin
            sb.push_back({m_hold, 16'h0100});
            m_hold_v = 1'b0;
        end
    endtask

    // Offer one instruction; returns 1 time unit after the accepting edge.
    task automatic drive(input logic [31:0] instr, input logic last,
                         input logic is16, input logic [15:0] hw);
        int n;
        in_valid = 1'b1;
        in_instr = instr;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        if (in_ready) model_accept(instr, last, is16, hw);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Output monitor: every consumed word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) chk("out_word", out_word, sb.pop_front());
        end
    end

    initial begin
        // reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_c16", {16'd0, c16_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi + li pair into one word
        drive(32'h00150513, 1'b0, 1'b1, 16'h0505);
        chk("pair_busy_mid", {31'd0, busy}, 32'd1);
        drive(32'h00500513, 1'b0, 1'b1, 16'h4515);
        chk("pair_c16", {16'd0, c16_cnt}, 32'd2);
        chk("pair_busy", {31'd0, busy}, 32'd0);

        // 32-bit with empty hold, one-cycle latency
        drive(32'h123452B7, 1'b0, 1'b0, 16'h0);
        chk("lui_valid", {31'd0, out_valid}, 32'd1);
        chk("lui_word", out_word, 32'hB7523412);
        chk("lui_c16", {16'd0, c16_cnt}, 32'd2);

        // split 32-bit instruction and flush padding
        drive(32'h00150513, 1'b0, 1'b1, 16'h0505);
        drive(32'h123452B7, 1'b1, 1'b0, 16'h0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd1);
        chk("split_word", out_word, 32'h0505B752);
        @(posedge clk);
        #1;
        chk("flush_word", out_word, 32'h34120100);
        chk("post_flush_busy", {31'd0, busy}, 32'd0);
        chk("post_flush_ready", {31'd0, in_ready}, 32'd1);

        // loads: two compressible, then rd outside x8..x15
        drive(32'h0044A403, 1'b0, 1'b1, 16'h40C0);
        drive(32'h0044A403, 1'b0, 1'b1, 16'h40C0);
        drive(32'h0044A803, 1'b0, 1'b0, 16'h0);

        // remaining forms and immediate/offset boundaries
        drive(32'h00B00533, 1'b0, 1'b1, 16'h852E);   // mv x10,x11
        drive(32'h00B50533, 1'b0, 1'b1, 16'h952E);   // add x10,x10,x11
        drive(32'h00942423, 1'b0, 1'b1, 16'hC404);   // sw x9,8(x8)
        drive(32'hFE050513, 1'b0, 1'b1, 16'h1501);   // addi x10,x10,-32
        drive(32'h02050513, 1'b0, 1'b0, 16'h0);      // addi x10,x10,32
        drive(32'h00050513, 1'b0, 1'b0, 16'h0);      // addi x10,x10,0
        drive(32'h07C4A403, 1'b0, 1'b1, 16'h5CE0);   // lw x8,124(x9)
        drive(32'h0804A403, 1'b0, 1'b0, 16'h0);      // lw x8,128(x9)
        drive(32'h00000063, 1'b1, 1'b0, 16'h0);      // beq, last with pending half
        @(posedge clk);
        #1;
        chk("cnt_after_forms", {16'd0, c16_cnt}, m_cnt);

        // last with nothing pending stays in RUN
        drive(32'h123452B7, 1'b1, 1'b0, 16'h0);
        chk("last_nopend_busy", {31'd0, busy}, 32'd0);
        chk("last_nopend_ready", {31'd0, in_ready}, 32'd1);

        // backpressure
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        drive(32'h123452B7, 1'b0, 1'b0, 16'h0);
        in_valid = 1'b1;
        in_instr = 32'h02050513;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_word", out_word, 32'hB7523412);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drive(32'h02050513, 1'b0, 1'b0, 16'h0);
        drive(32'h00150513, 1'b0, 1'b1, 16'h0505);
        drive(32'h00500513, 1'b0, 1'b1, 16'h4515);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_after_bp", {16'd0, c16_cnt}, m_cnt);

        // compression disabled
        nc_in_valid = 1'b1;
        nc_in_instr = 32'h00150513;
        @(negedge clk);
        chk("nc_in_ready", {31'd0, nc_in_ready}, 32'd1);
        @(posedge clk);
        #1 nc_in_valid = 1'b0;
        chk("nc_out_valid", {31'd0, nc_out_valid}, 32'd1);
        chk("nc_out_word", nc_out_word, 32'h13051500);
        chk("nc_c16", {16'd0, nc_c16}, 32'd0);

        // counter saturation on a 2-bit counter
        sat_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 sat_in_valid = 1'b0;
        chk("sat_c16", {30'd0, sat_c16}, 32'd3);

        // async reset while a halfword is pending
        drive(32'h00150513, 1'b0, 1'b1, 16'h0505);
        drive(32'h123452B7, 1'b0, 1'b0, 16'h0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        m_hold_v = 1'b0;
        m_cnt = 0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_c16", {16'd0, c16_cnt}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // everything expected must have been produced
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        chk("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
